// File: rtl/vga_timing_if.sv
// Timing bus between the VGA pixel-timing generator and its consumers.
// The generator (master) drives the counters, syncs, strobes and frame count.
// The consumer (slave) drives the pixel advance enable.
interface vga_timing_if #(
    parameter int FRAME_W = 9
);
    logic               en;
    logic [9:0]         hpos;
    logic [9:0]         vpos;
    logic               hsync;
    logic               vsync;
    logic               display_on;
    logic               line_start;
    logic               frame_start;
    logic [FRAME_W-1:0] frame_no;

    modport master (
        input  en,
        output hpos, vpos, hsync, vsync, display_on,
               line_start, frame_start, frame_no
    );

    modport slave (
        output en,
        input  hpos, vpos, hsync, vsync, display_on,
               line_start, frame_start, frame_no
    );
endinterface

// File: rtl/vga_timing_gen.sv
// VGA pixel-timing generator: raster counters, sync pulses, display window,
// line/frame strobes and a frame counter, all registered and mutually aligned.
// The frame counter is advanced on the clock, never on the sync pin itself.
module vga_timing_gen #(
    parameter int H_DISPLAY  = 640,
    parameter int H_FRONT    = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BACK     = 48,
    parameter int V_DISPLAY  = 480,
    parameter int V_FRONT    = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BACK     = 33,
    parameter int H_SYNC_POL = 0,
    parameter int V_SYNC_POL = 0,
    parameter int FRAME_W    = 9
) (
    input  logic         clk,
    input  logic         rst_n,
    vga_timing_if.master io_vga
);
    localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

    localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS    = 10'(H_DISPLAY);
    localparam logic [9:0] V_VIS    = 10'(V_DISPLAY);
    localparam logic [9:0] HS_START = 10'(H_DISPLAY + H_FRONT);
    localparam logic [9:0] HS_END   = 10'(H_DISPLAY + H_FRONT + H_SYNC - 1);
    localparam logic [9:0] VS_START = 10'(V_DISPLAY + V_FRONT);
    localparam logic [9:0] VS_END   = 10'(V_DISPLAY + V_FRONT + V_SYNC - 1);
    localparam logic       HS_ACT   = 1'(H_SYNC_POL);
    localparam logic       VS_ACT   = 1'(V_SYNC_POL);

    logic [9:0]         r_hpos;
    logic [9:0]         r_vpos;
    logic               r_hsync;
    logic               r_vsync;
    logic               r_display_on;
    logic               r_line_start;
    logic               r_frame_start;
    logic [FRAME_W-1:0] r_frame_no;

    logic [9:0]         w_hpos_next;
    logic [9:0]         w_vpos_next;
    logic               w_hsync_next;
    logic               w_vsync_next;
    logic               w_display_next;
    logic               w_line_next;
    logic               w_frame_next;
    logic               w_vblank_entry;

    // Next raster position if this edge advances.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        w_hpos_next = r_hpos + 10'd1;
        w_vpos_next = r_vpos;
        if (r_hpos == H_LAST) begin
            w_hpos_next = '0;
            w_vpos_next = (r_vpos == V_LAST) ? '0 : r_vpos + 10'd1;
        end
    end

    // Decodes taken from the next position so they land in the same cycle as it.
    assign w_hsync_next   = (w_hpos_next >= HS_START && w_hpos_next <= HS_END) ? HS_ACT : ~HS_ACT;
    assign w_vsync_next   = (w_vpos_next >= VS_START && w_vpos_next <= VS_END) ? VS_ACT : ~VS_ACT;
    assign w_display_next = (w_hpos_next < H_VIS) && (w_vpos_next < V_VIS);
    assign w_line_next    = (w_hpos_next == '0);
    assign w_frame_next   = w_line_next && (w_vpos_next == '0);
    assign w_vblank_entry = w_line_next && (w_vpos_next == V_VIS);

    // Raster state: synchronous reset to the last pixel of a virtual previous frame.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (!rst_n) begin
            r_hpos        <= H_LAST;
            r_vpos        <= V_LAST;
            r_hsync       <= ~HS_ACT;
            r_vsync       <= ~VS_ACT;
            r_display_on  <= 1'b0;
            r_line_start  <= 1'b0;
            r_frame_start <= 1'b0;
            r_frame_no    <= '0;
        end else begin
            // Strobes only survive one clock; a held edge clears them.
            r_line_start  <= 1'b0;
            r_frame_start <= 1'b0;
            if (io_vga.en) begin
                r_hpos        <= w_hpos_next;
                r_vpos        <= w_vpos_next;
                r_hsync       <= w_hsync_next;
                r_vsync       <= w_vsync_next;
                r_display_on  <= w_display_next;
                r_line_start  <= w_line_next;
                r_frame_start <= w_frame_next;
                // Bump at the start of vertical blanking so the count is steady over visible pixels.
                if (w_vblank_entry) begin
                    r_frame_no <= r_frame_no + FRAME_W'(1);
                end
            end
        end
    end

    assign io_vga.hpos        = r_hpos;
    assign io_vga.vpos        = r_vpos;
    assign io_vga.hsync       = r_hsync;
    assign io_vga.vsync       = r_vsync;
    assign io_vga.display_on  = r_display_on;
    assign io_vga.line_start  = r_line_start;
    assign io_vga.frame_start = r_frame_start;
    assign io_vga.frame_no    = r_frame_no;
endmodule
